phase_decompression_13: RTL



---
 rtl/phase_defs_pkg.sv | 32 +++
 rtl/phase_decompression_13_pipe_delay.sv | 25 ++
 rtl/phase_decompression_13.sv | 79 +++++++
 3 files changed

// File: rtl/phase_defs_pkg.sv
// Shared phase/octant definitions for the compression and decompression stages
// of the ROM/CORDIC sine-cosine generator.
package phase_defs;

  localparam int PHASE_W = 16;
  localparam int OCT_W   = 3;
  localparam int REA_W   = 6;
  localparam int COR_W   = 7;
  localparam int DW_DEF  = 16;

  // Octant bit positions: swap = b1^b0, sine sign = b2, cosine sign = b2^b1
  localparam int OCT_SWAP_LO    = 0;
  localparam int OCT_SWAP_HI    = 1;
  localparam int OCT_SIN_NEG    = 2;
  localparam int OCT_COS_NEG_LO = 1;
  localparam int OCT_COS_NEG_HI = 2;

  typedef logic [OCT_W-1:0] oct_t;

  function automatic logic oct_swap(input oct_t oct);
    return oct[OCT_SWAP_LO] ^ oct[OCT_SWAP_HI];
  endfunction

  function automatic logic oct_sin_neg(input oct_t oct);
    return oct[OCT_SIN_NEG];
  endfunction

  function automatic logic oct_cos_neg(input oct_t oct);
    return oct[OCT_COS_NEG_LO] ^ oct[OCT_COS_NEG_HI];
  endfunction

endpackage

// File: rtl/phase_decompression_13_pipe_delay.sv
// N-stage register shift line with asynchronous active-high clear.
module pipe_delay #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] tap [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) tap[k] <= '0;
    end else begin
      tap[0] <= din;
      for (int k = 1; k < N; k++) tap[k] <= tap[k-1];
    end
  end

  assign dout = tap[N-1];

endmodule

// File: rtl/phase_decompression_13.sv
// Restores full-circle signed sine/cosine from folded first-octant magnitudes
// using the octant index delayed to line up with the ROM output.
module phase_decompression_13
  import phase_defs::*;
#(
  parameter int DW      = DW_DEF,
  parameter int ROM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OCT_W-1:0]     index_qua,
  input  logic                 trans_in,
  input  logic [DW-1:0]        sin_fold,
  input  logic [DW-1:0]        cos_fold,
  output logic signed [DW:0]   sin_out,
  output logic signed [DW:0]   cos_out,
  output logic                 trans_out
);

  function automatic logic signed [DW:0] apply_sign(input logic [DW-1:0] mag,
                                                    input logic neg);
    logic signed [DW:0] ext;
    ext = signed'({1'b0, mag});
    return neg ? -ext : ext;
  endfunction

  oct_t oct_d;

  pipe_delay #(.W(OCT_W), .N(ROM_LAT)) u_oct_line (
    .clk   (clk),
    .reset (reset),
    .din   (index_qua),
    .dout  (oct_d)
  );

  pipe_delay #(.W(1), .N(ROM_LAT + 2)) u_vld_line (
    .clk   (clk),
    .reset (reset),
    .din   (trans_in),
    .dout  (trans_out)
  );

  logic [DW-1:0]       mag_s_p0;
  logic [DW-1:0]       mag_c_p0;
  logic                neg_s_p0;
  logic                neg_c_p0;
  logic signed [DW:0]  sin_p1;
  logic signed [DW:0]  cos_p1;

  // Stage A: swap magnitudes and decode signs from the aligned octant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_s_p0 <= '0;
      mag_c_p0 <= '0;
      neg_s_p0 <= 1'b0;
      neg_c_p0 <= 1'b0;
    end else begin
      mag_s_p0 <= oct_swap(oct_d) ? cos_fold : sin_fold;
      mag_c_p0 <= oct_swap(oct_d) ? sin_fold : cos_fold;
      neg_s_p0 <= oct_sin_neg(oct_d);
      neg_c_p0 <= oct_cos_neg(oct_d);
    end
  end

  // Stage B: signed restore; one extra bit keeps the full magnitude range
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sin_p1 <= '0;
      cos_p1 <= '0;
    end else begin
      sin_p1 <= apply_sign(mag_s_p0, neg_s_p0);
      cos_p1 <= apply_sign(mag_c_p0, neg_c_p0);
    end
  end

  assign sin_out = sin_p1;
  assign cos_out = cos_p1;

endmodule
